// File: rtl/pwm_shader_pkg.sv
// -----------------------------------------------------------------------------
// pwm_shader_pkg
// Shared defaults and helpers for the PWM row shader.
//   PWM_CHANNELS_DEF : default number of row outputs
//   PWM_WIDTH_DEF    : default intensity bits per channel (period = 2^WIDTH)
//   PWM_DIV_DEF      : default clocks per PWM step
//   PWM_WIDTH_MAX    : widest intensity the gamma helper supports
//   gamma_sq()       : square-law intensity map, (v*v) >> width
// -----------------------------------------------------------------------------
package pwm_shader_pkg;

  localparam int PWM_CHANNELS_DEF = 32;
  localparam int PWM_WIDTH_DEF    = 5;
  localparam int PWM_DIV_DEF      = 1;
  localparam int PWM_WIDTH_MAX    = 16;

  // The full 2*W-bit product is formed before the shift, so no high bits are
  // lost; the result always fits back into W bits.
  function automatic logic [PWM_WIDTH_MAX-1:0] gamma_sq(
    input logic [PWM_WIDTH_MAX-1:0] v,
    input int                       width
  );
    logic [2*PWM_WIDTH_MAX-1:0] prod;
    logic [2*PWM_WIDTH_MAX-1:0] shifted;
    prod    = {{PWM_WIDTH_MAX{1'b0}}, v} * {{PWM_WIDTH_MAX{1'b0}}, v};
    shifted = prod >> width;
    return shifted[PWM_WIDTH_MAX-1:0];
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Step prescaler and phase counter shared by all PWM channels.
//   clk          : sole clock, rising edge
//   rst_n        : asynchronous active-low reset
//   en           : run enable; when low the prescaler and phase hold
//   phase        : current step within the period (0 .. 2^WIDTH-1)
//   boundary     : combinational, high in the cycle of the tick that wraps phase
//   period_start : registered one-clock pulse on the edge after a boundary tick
// -----------------------------------------------------------------------------
module pwm_timebase
  import pwm_shader_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEF,
  parameter int DIV   = PWM_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] phase,
  output logic             boundary,
  output logic             period_start
);

  // A 1-bit prescaler is kept even for DIV=1; it simply stays at zero.
  localparam int               PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST   = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] PHASE_LAST = '1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick     = en && (presc == PRE_LAST);
  assign boundary = tick && (phase == PHASE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      phase        <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (en) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (tick) begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_shader.sv
// -----------------------------------------------------------------------------
// pwm_shader
// Multi-channel PWM row driver with a double-buffered duty set. A new word is
// taken into a pending buffer at any time the buffer is empty and becomes the
// active duty set only at a period boundary, so a running period is never
// torn.
// Optional build macro: PWM_SHADER_GAMMA_EN -- when defined, duties are mapped
// through (v*v) >> WIDTH as they move from pending to active.
//   clk          : sole clock, rising edge
//   rst_n        : asynchronous active-low reset
//   en           : run enable; rows go dark and the timebase holds when low
//   values_in    : CHANNELS x WIDTH duties, channel i at [WIDTH*i +: WIDTH]
//   values_valid : values_in is offered
//   values_ready : pending buffer empty (combinational)
//   rows         : registered active-high row drives
//   period_start : registered one-clock pulse at each period start
// -----------------------------------------------------------------------------
module pwm_shader
  import pwm_shader_pkg::*;
#(
  parameter int CHANNELS = PWM_CHANNELS_DEF,
  parameter int WIDTH    = PWM_WIDTH_DEF,
  parameter int DIV      = PWM_DIV_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] values_in,
  input  logic                      values_valid,
  output logic                      values_ready,
  output logic [CHANNELS-1:0]       rows,
  output logic                      period_start
);

  logic [WIDTH-1:0]          phase;
  logic                      boundary;
  logic [CHANNELS*WIDTH-1:0] pending;
  logic                      pending_full;
  logic                      accept;
  logic [WIDTH-1:0]          active [CHANNELS];
  logic [CHANNELS-1:0]       rows_p1;

  function automatic logic [WIDTH-1:0] shade(input logic [WIDTH-1:0] v);
`ifdef PWM_SHADER_GAMMA_EN
    return WIDTH'(gamma_sq(PWM_WIDTH_MAX'(v), WIDTH));
`else
    return v;
`endif
  endfunction

  pwm_timebase #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .phase        (phase),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign values_ready = !pending_full;
  assign accept       = values_valid && !pending_full;

  // Pending data needs no reset: it is only ever consumed while pending_full
  // is set, and that flag is cleared by reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pending <= values_in;
    end
  end

  // Stage p0 -> p1: duty compare against the current phase, registered onto rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_full <= 1'b0;
      rows_p1      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= '0;
      end
    end else begin
      // An accept can only happen while empty, so it never collides with a
      // transfer; a boundary with an empty buffer leaves the new word pending.
      if (accept) begin
        pending_full <= 1'b1;
      end else if (boundary) begin
        pending_full <= 1'b0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary && pending_full) begin
          active[i] <= shade(pending[WIDTH*i +: WIDTH]);
        end
        rows_p1[i] <= en && (phase < active[i]);
      end
    end
  end

  assign rows = rows_p1;

endmodule

// File: tb/tb_pwm_shader.sv
// -----------------------------------------------------------------------------
// tb_pwm_shader
// Directed bench for pwm_shader: a DIV=1 32-channel instance for the main
// behaviour and a DIV=4 4-channel instance for the enable-gap stretch.
// -----------------------------------------------------------------------------
module tb_pwm_shader;

  localparam int CH = 32;
  localparam int W  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [CH*W-1:0] values_in;
  logic            values_valid;
  logic            values_ready;
  logic [CH-1:0]   rows;
  logic            period_start;

  logic            en4;
  logic [4*W-1:0]  vals4;
  logic            valid4;
  logic            ready4;
  logic [3:0]      rows4;
  logic            ps4;

  int n_vec = 0;
  int n_err = 0;
  int cnt [CH];
  logic ps_seen;

  always #5 clk = ~clk;

  pwm_shader #(.CHANNELS(CH), .WIDTH(W), .DIV(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .values_in    (values_in),
    .values_valid (values_valid),
    .values_ready (values_ready),
    .rows         (rows),
    .period_start (period_start)
  );

  pwm_shader #(.CHANNELS(4), .WIDTH(W), .DIV(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en4),
    .values_in    (vals4),
    .values_valid (valid4),
    .values_ready (ready4),
    .rows         (rows4),
    .period_start (ps4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] fill(input logic [W-1:0] v);
    logic [CH*W-1:0] r;
    for (int i = 0; i < CH; i++) r[W*i +: W] = v;
    return r;
  endfunction

  task automatic load(input logic [CH*W-1:0] v);
    values_in    = v;
    values_valid = 1'b1;
    @(negedge clk);
    values_valid = 1'b0;
  endtask

  task automatic wait_ps(input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!period_start && t < 200);
    check(tag, period_start, 1);
  endtask

  // Counts high samples per channel over ncyc clocks. Optionally raises
  // values_valid with lv at sample raise_at and drops it at drop_at, checking
  // that the word was taken (values_ready low) at the drop.
  task automatic count_rows(input int ncyc, input int raise_at, input int drop_at,
                            input logic [CH*W-1:0] lv);
    for (int c = 0; c < CH; c++) cnt[c] = 0;
    ps_seen = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) if (rows[c]) cnt[c]++;
      if (k == ncyc) ps_seen = period_start;
      if (k == raise_at) begin
        values_in    = lv;
        values_valid = 1'b1;
      end
      if (k == drop_at) begin
        check("ready_low_after_accept", values_ready, 0);
        values_valid = 1'b0;
      end
    end
  endtask

  initial begin : stim
    logic [CH*W-1:0] v;
    int t;
    int total;
    logic any_row;

    rst_n = 1'b0; en = 1'b0; values_in = '0; values_valid = 1'b0;
    en4 = 1'b0; vals4 = '0; valid4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rows", rows, 0);
    check("rst_ps", period_start, 0);
    check("rst_rows4", rows4, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", values_ready, 1);
    check("ready4_after_rst", ready4, 1);

    // DIV=4: en dropped for 7 clocks at n=12 stretches the period to 135
    vals4  = {4{5'd20}};
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    en4    = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ps4 && t < 300);
    check("ps4_first", ps4, 1);
    t = 0;
    any_row = 1'b0;
    do begin
      @(negedge clk);
      t++;
      if (t == 48) begin
        check("rows4_before_gap", rows4, 4'hF);
        en4 = 1'b0;
      end
      if (t >= 49 && t <= 55) any_row = any_row | (|rows4);
      if (t == 55) en4 = 1'b1;
    end while (!ps4 && t < 400);
    check("rows4_dark_in_gap", any_row, 0);
    check("div4_period_len", t, 135);
    en4 = 1'b0;

    // All channels at 10, loaded while disabled
    load(fill(5'd10));
    check("ready_low_pending", values_ready, 0);
    en = 1'b1;
    wait_ps("ps_first");
    check("ready_after_transfer", values_ready, 1);
    count_rows(32, 0, 0, '0);
    check("all10_ch0", cnt[0], 10);
    check("all10_ch31", cnt[31], 10);
    t = 0;
    for (int c = 0; c < CH; c++) if (cnt[c] == 10) t++;
    check("all10_count", t, CH);
    check("all10_ps_end", ps_seen, 1);

    // ch0=20, ch1=31 (max), ch2=0 (min); then ch0=3 loaded mid-period
    v = fill(5'd10);
    v[0 +: W] = 5'd20; v[W +: W] = 5'd31; v[2*W +: W] = 5'd0;
    load(v);
    wait_ps("ps_mix");
    v[0 +: W] = 5'd3;
    count_rows(32, 5, 6, v);
    check("mix_ch0_20", cnt[0], 20);
    check("mix_ch1_31", cnt[1], 31);
    check("mix_ch2_0", cnt[2], 0);
    check("mix_ch5_10", cnt[5], 10);
    check("mix_ps_end", ps_seen, 1);
    count_rows(32, 0, 0, '0);
    check("switch_ch0_3", cnt[0], 3);
    check("switch_ch1_31", cnt[1], 31);

    // Back-to-back: A (ch0=7) then B (ch0=25) held until accepted
    v = fill(5'd10);
    v[0 +: W] = 5'd7;
    load(v);
    check("b2b_ready_low", values_ready, 0);
    v[0 +: W] = 5'd25;
    values_in    = v;
    values_valid = 1'b1;
    wait_ps("ps_b2b");
    check("b2b_ready_at_boundary", values_ready, 1);
    count_rows(32, 0, 1, '0);
    check("b2b_first_ch0_7", cnt[0], 7);
    count_rows(32, 0, 0, '0);
    check("b2b_second_ch0_25", cnt[0], 25);

    // Duty/gamma map for 31/16/5/0
    v = '0;
    v[0 +: W] = 5'd31; v[W +: W] = 5'd16; v[2*W +: W] = 5'd5; v[3*W +: W] = 5'd0;
    load(v);
    wait_ps("ps_gamma");
    count_rows(32, 0, 0, '0);
`ifdef PWM_SHADER_GAMMA_EN
    check("duty_31", cnt[0], 30);
    check("duty_16", cnt[1], 8);
    check("duty_5", cnt[2], 0);
`else
    check("duty_31", cnt[0], 31);
    check("duty_16", cnt[1], 16);
    check("duty_5", cnt[2], 5);
`endif
    check("duty_0", cnt[3], 0);

    // Reset at n=17 with pending full
    load(fill(5'd10));
    repeat (16) @(negedge clk);
    check("pending_full_before_rst", values_ready, 0);
    check("row0_high_before_rst", rows[0], 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rows", rows, 0);
    check("midrst_ps", period_start, 0);
    check("midrst_ready", values_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    count_rows(64, 0, 0, '0);
    total = 0;
    for (int c = 0; c < CH; c++) total += cnt[c];
    check("dark_after_rst", total, 0);
    load(fill(5'd10));
    wait_ps("ps_after_rst");
    count_rows(32, 0, 0, '0);
    check("reload_ch7_10", cnt[7], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
